// File: rtl/inst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : inst_feeder
// Purpose  : Fetches a run of instructions as narrow memory beats, reassembles
//            them and serves them through a small FWFT queue.
//            Optional type-field filter: INST_FEEDER_TYPE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module inst_feeder #(
    parameter int INST_LEN     = 220,
    parameter int MEM_DW       = 64,
    parameter int BEATS        = 4,
    parameter int DEPTH        = 4,
    parameter int DDR_ADDR_LEN = 32,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DDR_ADDR_LEN-1:0] base_addr,
    input  logic [CNT_LEN-1:0]      inst_count,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_req,
    output logic [DDR_ADDR_LEN-1:0] rd_addr,
    input  logic                    rd_ready,
    input  logic                    rd_valid,
    input  logic [MEM_DW-1:0]       rd_data,
    output logic [INST_LEN-1:0]     instruct,
    output logic                    inst_empty,
    input  logic                    inst_req,
    output logic [CNT_LEN-1:0]      err_cnt
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_OCC_W  = $clog2(DEPTH + 1);
    localparam int c_BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_ASM_W  = (BEATS - 1) * MEM_DW;
    localparam logic [DDR_ADDR_LEN-1:0] c_STRIDE    = DDR_ADDR_LEN'(MEM_DW / 8);
    localparam logic [c_BEAT_W-1:0]     c_LAST_BEAT = c_BEAT_W'(BEATS - 1);
    localparam logic [c_OCC_W:0]        c_DEPTH     = (c_OCC_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_done, r_rd_req;
    logic [DDR_ADDR_LEN-1:0] r_rd_addr;
    logic [CNT_LEN-1:0]      r_inst_left, r_resp_left;
    logic [c_BEAT_W-1:0]     r_nxt_beat, r_asm_beat;
    logic [c_OCC_W-1:0]      r_inflight, r_count;
    logic [c_PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_ASM_W-1:0]      r_asm;
    logic [INST_LEN-1:0]     r_q [DEPTH];

    logic                    w_idle, w_start_ok, w_zero_run, w_slot, w_credit;
    logic                    w_issue, w_first, w_accept, w_all_req;
    logic                    w_beat_in, w_last_in, w_drop, w_push, w_pop, w_final;
    logic [CNT_LEN-1:0]      w_left;
    logic [c_BEAT_W-1:0]     w_beat;
    logic [c_OCC_W:0]        w_sum;
    logic [INST_LEN-1:0]     w_word;

    assign w_idle     = (r_state == S_IDLE);
    assign w_start_ok = w_idle && start && (inst_count != '0);
    assign w_zero_run = w_idle && start && (inst_count == '0);
    // In IDLE the accepted start feeds the issue logic directly so the first
    // request appears the cycle after start.
    assign w_left     = w_idle ? inst_count : r_inst_left;
    assign w_beat     = w_idle ? '0 : r_nxt_beat;
    assign w_slot     = !r_rd_req || rd_ready;
    assign w_sum      = (c_OCC_W + 1)'(r_count) + (c_OCC_W + 1)'(r_inflight);
    assign w_credit   = (w_sum < c_DEPTH);
    assign w_issue    = w_slot && (w_idle ? w_start_ok : (r_state == S_FETCH))
                        && ((w_beat != '0) || ((w_left != '0) && w_credit));
    assign w_first    = w_issue && (w_beat == '0);
    assign w_accept   = r_rd_req && rd_ready;
    assign w_all_req  = (r_inst_left == '0) && (r_nxt_beat == '0) && w_slot;

    assign w_beat_in  = rd_valid && !w_idle;
    assign w_last_in  = w_beat_in && (r_asm_beat == c_LAST_BEAT);
    assign w_word     = INST_LEN'({rd_data, r_asm});
    assign w_push     = w_last_in && !w_drop;
    assign w_pop      = inst_req && (r_count != '0);
    assign w_final    = w_last_in && (r_resp_left == CNT_LEN'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_final)        w_state_nxt = S_IDLE;
                else if (w_all_req) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_final) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_inst_left <= '0;
            r_resp_left <= '0;
            r_nxt_beat  <= '0;
            r_inflight  <= '0;
            r_asm_beat  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_zero_run || w_final;
            if (w_slot) r_rd_req <= w_issue;

            if (w_start_ok)    r_rd_addr <= base_addr;
            else if (w_accept) r_rd_addr <= r_rd_addr + c_STRIDE;

            if (w_start_ok)     r_resp_left <= inst_count;
            else if (w_last_in) r_resp_left <= r_resp_left - CNT_LEN'(1);

            if (w_issue) begin
                r_inst_left <= w_first ? (w_left - CNT_LEN'(1)) : w_left;
                r_nxt_beat  <= (w_beat == c_LAST_BEAT) ? '0 : (w_beat + c_BEAT_W'(1));
            end else if (w_start_ok) begin
                r_inst_left <= inst_count;
                r_nxt_beat  <= '0;
            end

            // Credit is claimed when a first beat is presented and returned on push or drop.
            r_inflight <= r_inflight + c_OCC_W'(w_first) - c_OCC_W'(w_last_in);

            if (w_beat_in)
                r_asm_beat <= (r_asm_beat == c_LAST_BEAT) ? '0 : (r_asm_beat + c_BEAT_W'(1));

            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_OCC_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_in && (r_asm_beat != c_LAST_BEAT))
            r_asm[int'(r_asm_beat) * MEM_DW +: MEM_DW] <= rd_data;
        if (w_push)
            r_q[r_wr_ptr] <= w_word;
    end

`ifdef INST_FEEDER_TYPE_CHECK_EN
    logic [CNT_LEN-1:0] r_err;

    assign w_drop = (w_word[3:0] > 4'd3);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= '0;
        else if (w_last_in && w_drop && (r_err != '1))
            r_err <= r_err + CNT_LEN'(1);
    end

    assign err_cnt = r_err;
`else
    assign w_drop  = 1'b0;
    assign err_cnt = '0;
`endif

    assign busy       = !w_idle;
    assign done       = r_done;
    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign inst_empty = (r_count == '0);
    assign instruct   = (r_count == '0) ? '0 : r_q[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_inst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_feeder
// Purpose  : Self-checking bench for inst_feeder with a fixed-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_feeder;

    localparam int INST_LEN = 220;
    localparam int MEM_DW   = 64;
    localparam int AW       = 32;
    localparam int CW       = 16;

    logic                clk, rst_n, start;
    logic [AW-1:0]       base_addr;
    logic [CW-1:0]       inst_count;
    logic                busy, done, rd_req, rd_ready, rd_valid;
    logic [AW-1:0]       rd_addr;
    logic [MEM_DW-1:0]   rd_data;
    logic [INST_LEN-1:0] instruct;
    logic                inst_empty, inst_req;
    logic [CW-1:0]       err_cnt;

    inst_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .inst_count (inst_count),
        .busy       (busy),
        .done       (done),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .instruct   (instruct),
        .inst_empty (inst_empty),
        .inst_req   (inst_req),
        .err_cnt    (err_cnt)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    int          mcyc = 0;
    bit          mem_stall = 0;
    bit          typ_en = 0;
    logic [31:0] typ_base = '0;
    int          typ_val[8];
    int          exp_idx[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory image: each beat carries its own address; beat 0 of an
    // instruction may have its type nibble overridden.
    function automatic logic [63:0] mem_data(input logic [31:0] a);
        logic [63:0] d;
        logic [31:0] off;
        d   = {a ^ 32'hC3A5_5A3C, a};
        off = a - typ_base;
        if (typ_en && off[4:0] == 5'd0 && off < 32'd256)
            d[3:0] = 4'(typ_val[off[7:5]]);
        return d;
    endfunction

    function automatic logic [219:0] exp_inst(input logic [31:0] base, input int i);
        logic [255:0] w;
        for (int j = 0; j < 4; j++)
            w[j*64 +: 64] = mem_data(base + 32'((i * 4 + j) * 8));
        return w[219:0];
    endfunction

    // Memory: accepts on rd_req && rd_ready, returns each beat two cycles later.
    initial begin
        rd_ready = 1'b1;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            rd_ready = mem_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_req && rd_ready) begin
                pend_addr.push_back(rd_addr);
                pend_due.push_back(mcyc + 2);
                req_log.push_back(rd_addr);
            end
            if (pend_due.size() > 0 && pend_due[0] == mcyc) begin
                rd_valid = 1'b1;
                rd_data  = mem_data(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                rd_valid = 1'b0;
                rd_data  = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [219:0] act, input logic [219:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " rd_req"}, rd_req, 1'b0);
        chk({tag, " rd_addr"}, rd_addr, 32'h0);
        chk({tag, " instruct"}, instruct, '0);
        chk({tag, " err_cnt"}, err_cnt, 16'h0);
        chk({tag, " inst_empty"}, inst_empty, 1'b1);
    endtask

    // Starts a run and, when do_pop is set, consumes and checks exp_idx in order.
    task automatic run(input logic [31:0] base, input int cnt, input bit do_pop,
                       input string tag, output int first_ne);
        int got, dones, k, bad;
        got = 0; dones = 0; first_ne = -1;
        req_log.delete();
        base_addr = base; inst_count = 16'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        if (cnt > 0) begin
            chk({tag, " busy@1"}, busy, 1'b1);
            chk({tag, " rd_req@1"}, rd_req, 1'b1);
            chk({tag, " rd_addr@1"}, rd_addr, base);
        end
        while (k < 400 && !(dones > 0 && (!do_pop || got >= exp_idx.size()))) begin
            inst_req = 1'b0;
            if (done) begin
                dones++;
                chk({tag, " busy at done"}, busy, 1'b0);
            end
            if (!inst_empty && first_ne < 0) first_ne = k;
            if (do_pop && !inst_empty) begin
                if (got < exp_idx.size())
                    chk($sformatf("%s inst%0d", tag, got), instruct, exp_inst(base, exp_idx[got]));
                else
                    fail_now({tag, " unexpected extra instruction"});
                inst_req = 1'b1;
                got++;
            end
            tick();
            k++;
        end
        inst_req = 1'b0;
        chk({tag, " done pulses"}, 220'(dones), 220'(1));
        if (do_pop) chk({tag, " delivered"}, 220'(got), 220'(exp_idx.size()));
        bad = 0;
        foreach (req_log[i]) if (req_log[i] !== base + 32'(i * 8)) bad++;
        chk({tag, " addr seq errors"}, 220'(bad), 220'(0));
    endtask

    typedef struct {
        logic [31:0] base;
        int          cnt;
        bit          stall;
        int          nreq_exp;
        logic [31:0] last_exp;
        int          first_exp;   // -2: not checked
    } vec_t;

    vec_t tbl[5];

    initial begin
        int fne, dn, got, k, pops;
        tbl[0] = '{32'h0000_1000, 3, 1'b0, 12, 32'h0000_1058, 7};
        tbl[1] = '{32'hFFFF_FFF0, 1, 1'b0, 4,  32'h0000_0008, 7};
        tbl[2] = '{32'h0000_0040, 2, 1'b1, 8,  32'h0000_0078, -2};
        tbl[3] = '{32'h0000_2000, 0, 1'b0, 0,  32'h0000_0000, -1};
        tbl[4] = '{32'h0000_0100, 5, 1'b0, 20, 32'h0000_0198, 7};

        rst_n = 1'b0; start = 1'b0; inst_req = 1'b0;
        base_addr = '0; inst_count = '0;
        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            exp_idx.delete();
            for (int j = 0; j < tbl[i].cnt; j++) exp_idx.push_back(j);
            mem_stall = tbl[i].stall;
            run(tbl[i].base, tbl[i].cnt, 1'b1, $sformatf("v%0d", i), fne);
            mem_stall = 1'b0;
            chk($sformatf("v%0d nreq", i), 220'(req_log.size()), 220'(tbl[i].nreq_exp));
            if (tbl[i].cnt > 0 && req_log.size() > 0)
                chk($sformatf("v%0d last addr", i), req_log[req_log.size()-1], tbl[i].last_exp);
            if (tbl[i].first_exp != -2)
                chk($sformatf("v%0d first visible", i), 220'(fne), 220'(tbl[i].first_exp));
            repeat (3) tick();
        end

        // Credit limit: no pops, then a single pop, then drain with pops.
        req_log.delete();
        base_addr = 32'h3000; inst_count = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        repeat (60) begin if (done) dn++; tick(); end
        chk("credit reqs before pop", 220'(req_log.size()), 220'(16));
        chk("credit queue non-empty", inst_empty, 1'b0);
        chk("credit busy", busy, 1'b1);
        chk("credit head", instruct, exp_inst(32'h3000, 0));
        inst_req = 1'b1;
        tick();
        inst_req = 1'b0;
        repeat (30) begin if (done) dn++; tick(); end
        chk("credit reqs after one pop", 220'(req_log.size()), 220'(20));
        got = 1; k = 0;
        while (k < 300 && !(dn > 0 && got == 8)) begin
            inst_req = 1'b0;
            if (done) dn++;
            if (!inst_empty) begin
                if (got < 8) chk($sformatf("credit inst%0d", got), instruct, exp_inst(32'h3000, got));
                else fail_now("credit unexpected extra instruction");
                inst_req = 1'b1;
                got++;
            end
            tick();
            k++;
        end
        inst_req = 1'b0;
        chk("credit delivered", 220'(got), 220'(8));
        chk("credit done pulses", 220'(dn), 220'(1));
        chk("credit total reqs", 220'(req_log.size()), 220'(32));
        repeat (3) tick();

        // inst_req held for five cycles with two entries queued.
        exp_idx.delete();
        exp_idx.push_back(0); exp_idx.push_back(1);
        run(32'h6000, 2, 1'b0, "hold", fne);
        pops = 0;
        repeat (5) begin
            if (!inst_empty) begin
                if (pops < 2) chk($sformatf("hold head%0d", pops), instruct, exp_inst(32'h6000, pops));
                pops++;
            end
            inst_req = 1'b1;
            tick();
        end
        inst_req = 1'b0;
        chk("hold pops", 220'(pops), 220'(2));
        chk("hold empty", inst_empty, 1'b1);
        exp_idx.delete();
        exp_idx.push_back(0);
        run(32'h7000, 1, 1'b1, "after-hold", fne);
        repeat (3) tick();

        // Type filter.
        typ_en = 1'b1; typ_base = 32'hA000;
        typ_val[0] = 0; typ_val[1] = 7; typ_val[2] = 2;
        exp_idx.delete();
`ifdef INST_FEEDER_TYPE_CHECK_EN
        exp_idx.push_back(0); exp_idx.push_back(2);
        run(32'hA000, 3, 1'b1, "type", fne);
        chk("type err_cnt", err_cnt, 16'd1);
`else
        exp_idx.push_back(0); exp_idx.push_back(1); exp_idx.push_back(2);
        run(32'hA000, 3, 1'b1, "type", fne);
        chk("type err_cnt", err_cnt, 16'd0);
`endif
        typ_en = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a run with an entry already queued.
        req_log.delete();
        base_addr = 32'h8000; inst_count = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("midrst queued before reset", inst_empty, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_reset("midrst");
        rst_n = 1'b1;
        repeat (12) tick();
        chk("midrst stale beats ignored", inst_empty, 1'b1);
        chk("midrst idle", busy, 1'b0);
        exp_idx.delete();
        exp_idx.push_back(0); exp_idx.push_back(1);
        run(32'h9000, 2, 1'b1, "post-rst", fne);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
